// File: rtl/instruction_encoder_pkg.sv
// Shared DLX encoding definitions: widths, field offsets, opcodes and the request record.
// The decoder imports the same package, so the two sides cannot disagree on the format.
package instruction_encoder_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int OPCODE_WIDTH      = 6;
    localparam int FUNCTION_WIDTH    = 6;
    localparam int REG_ADDR_WIDTH    = 5;
    localparam int IMEDIATE_WIDTH    = 16;
    localparam int PC_OFFSET_WIDTH   = 26;
    localparam int IMEM_ADDR_WIDTH   = 10;

    // Field MSB positions; I-type places rd where R-type places rs2.
    localparam int OP_MSB   = 31;
    localparam int RS1_MSB  = 25;
    localparam int RS2_MSB  = 20;
    localparam int RDI_MSB  = 20;
    localparam int RD_MSB   = 15;
    localparam int IMM_MSB  = 15;
    localparam int FUNC_MSB = 5;
    localparam int PCO_MSB  = 25;

    localparam logic [OPCODE_WIDTH-1:0] OP_R_TYPE = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_JPC    = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQZ   = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNEZ   = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRFL   = 6'h06;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI   = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI   = 6'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI   = 6'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_ORI    = 6'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_JR     = 6'h12;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW     = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW     = 6'h2B;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH, ST_DONE} enc_state_e;

    typedef struct packed {
        logic                       nop;
        logic [OPCODE_WIDTH-1:0]    opcode;
        logic [FUNCTION_WIDTH-1:0]  func;
        logic [REG_ADDR_WIDTH-1:0]  rs1;
        logic [REG_ADDR_WIDTH-1:0]  rs2;
        logic [REG_ADDR_WIDTH-1:0]  rd;
        logic [IMEDIATE_WIDTH-1:0]  imm;
        logic [PC_OFFSET_WIDTH-1:0] pc_off;
    } enc_req_t;

    function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_R_TYPE, OP_JPC, OP_BEQZ, OP_BNEZ, OP_BRFL, OP_ADDI, OP_SUBI,
            OP_ANDI, OP_ORI, OP_JR, OP_LW, OP_SW: is_legal = 1'b1;
            default:                              is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Two-entry registered FIFO; the head is driven straight from storage so the
// write port outputs hold steady while the consumer stalls.
module encoder_fifo #(
    parameter int DATA_WIDTH = 42
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic [1:0][DATA_WIDTH-1:0] mem_q;
    logic                       wr_ptr_q, rd_ptr_q;
    logic [1:0]                 count_q;
    logic                       push, pop;

    // Ready depends only on occupancy, never on the consumer, to avoid comb paths.
    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded DLX instruction records into 32-bit words and streams them into
// instruction memory at consecutive addresses from a programmable base.
module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_in,
    input  logic [IMEM_ADDR_WIDTH-1:0]   base_addr_in,
    input  logic                         enc_valid_in,
    output logic                         enc_ready_out,
    input  logic                         last_in,
    input  logic                         nop_in,
    input  logic [OPCODE_WIDTH-1:0]      opcode_in,
    input  logic [FUNCTION_WIDTH-1:0]    inst_function_in,
    input  logic [REG_ADDR_WIDTH-1:0]    rs1_in,
    input  logic [REG_ADDR_WIDTH-1:0]    rs2_in,
    input  logic [REG_ADDR_WIDTH-1:0]    rd_in,
    input  logic [IMEDIATE_WIDTH-1:0]    immediate_in,
    input  logic [PC_OFFSET_WIDTH-1:0]   pc_offset_in,
    output logic                         imem_wr_en_out,
    input  logic                         imem_wr_ready_in,
    output logic [IMEM_ADDR_WIDTH-1:0]   imem_wr_addr_out,
    output logic [INSTRUCTION_WIDTH-1:0] imem_wr_data_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic                         err_illegal_out,
    output logic [7:0]                   err_count_out
);

    localparam int ENTRY_W = IMEM_ADDR_WIDTH + INSTRUCTION_WIDTH;

    function automatic logic [INSTRUCTION_WIDTH-1:0] pack(input enc_req_t r);
        logic [INSTRUCTION_WIDTH-1:0] w;
        w = '0;
        if (!r.nop) begin
            w[OP_MSB -: OPCODE_WIDTH] = r.opcode;
            case (r.opcode)
                OP_R_TYPE: begin
                    w[RS1_MSB -: REG_ADDR_WIDTH]  = r.rs1;
                    w[RS2_MSB -: REG_ADDR_WIDTH]  = r.rs2;
                    w[RD_MSB -: REG_ADDR_WIDTH]   = r.rd;
                    w[FUNC_MSB -: FUNCTION_WIDTH] = r.func;
                end
                OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LW: begin
                    w[RS1_MSB -: REG_ADDR_WIDTH] = r.rs1;
                    w[RDI_MSB -: REG_ADDR_WIDTH] = r.rd;
                    w[IMM_MSB -: IMEDIATE_WIDTH] = r.imm;
                end
                OP_SW: begin
                    w[RS1_MSB -: REG_ADDR_WIDTH] = r.rs1;
                    w[RS2_MSB -: REG_ADDR_WIDTH] = r.rs2;
                    w[IMM_MSB -: IMEDIATE_WIDTH] = r.imm;
                end
                OP_BEQZ, OP_BNEZ, OP_BRFL: begin
                    w[RS1_MSB -: REG_ADDR_WIDTH] = r.rs1;
                    w[IMM_MSB -: IMEDIATE_WIDTH] = r.imm;
                end
                OP_JR:   w[RS1_MSB -: REG_ADDR_WIDTH]  = r.rs1;
                OP_JPC:  w[PCO_MSB -: PC_OFFSET_WIDTH] = r.pc_off;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    enc_state_e                 state_q, state_d;
    logic [IMEM_ADDR_WIDTH-1:0] addr_q;
    logic                       err_illegal_q;
    logic [7:0]                 err_count_q;
    enc_req_t                   req;
    logic                       fifo_in_ready, accept, legal, push;
    logic [ENTRY_W-1:0]         fifo_head;

    assign req = '{nop: nop_in, opcode: opcode_in, func: inst_function_in, rs1: rs1_in,
                   rs2: rs2_in, rd: rd_in, imm: immediate_in, pc_off: pc_offset_in};

    assign enc_ready_out = (state_q == ST_ACTIVE) && fifo_in_ready;
    assign accept        = enc_valid_in && enc_ready_out;
    assign legal         = nop_in || is_legal(opcode_in);
    assign push          = accept && legal;

    encoder_fifo #(.DATA_WIDTH(ENTRY_W)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (push),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   ({addr_q, pack(req)}),
        .out_valid_o (imem_wr_en_out),
        .out_ready_i (imem_wr_ready_in),
        .out_data_o  (fifo_head)
    );

    assign {imem_wr_addr_out, imem_wr_data_out} = fifo_head;
    assign busy_out        = (state_q != ST_IDLE);
    assign done_out        = (state_q == ST_DONE);
    assign err_illegal_out = err_illegal_q;
    assign err_count_out   = err_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_in) state_d = ST_ACTIVE;
            ST_ACTIVE: if (accept && last_in) state_d = ST_FLUSH;
            ST_FLUSH:  if (!imem_wr_en_out) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            err_illegal_q <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            err_illegal_q <= accept && !legal;
            if (state_q == ST_IDLE && start_in) begin
                addr_q      <= base_addr_in;
                err_count_q <= 8'd0;
            end else begin
                if (push) addr_q <= addr_q + 1'b1;
                if (accept && !legal && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench: stimulus pushes expected {addr,data} into a scoreboard,
// a negedge monitor pops and compares each accepted imem write.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic [9:0]  base_addr_in = '0;
    logic        enc_valid_in = 1'b0;
    logic        enc_ready_out;
    logic        last_in = 1'b0;
    logic        nop_in = 1'b0;
    logic [5:0]  opcode_in = '0;
    logic [5:0]  inst_function_in = '0;
    logic [4:0]  rs1_in = '0, rs2_in = '0, rd_in = '0;
    logic [15:0] immediate_in = '0;
    logic [25:0] pc_offset_in = '0;
    logic        imem_wr_en_out;
    logic        imem_wr_ready_in = 1'b1;
    logic [9:0]  imem_wr_addr_out;
    logic [31:0] imem_wr_data_out;
    logic        busy_out, done_out, err_illegal_out;
    logic [7:0]  err_count_out;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;
    logic [41:0] sb[$];

    instruction_encoder dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in), .base_addr_in(base_addr_in),
        .enc_valid_in(enc_valid_in), .enc_ready_out(enc_ready_out), .last_in(last_in),
        .nop_in(nop_in), .opcode_in(opcode_in), .inst_function_in(inst_function_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .immediate_in(immediate_in),
        .pc_offset_in(pc_offset_in), .imem_wr_en_out(imem_wr_en_out),
        .imem_wr_ready_in(imem_wr_ready_in), .imem_wr_addr_out(imem_wr_addr_out),
        .imem_wr_data_out(imem_wr_data_out), .busy_out(busy_out), .done_out(done_out),
        .err_illegal_out(err_illegal_out), .err_count_out(err_count_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_wr_en_out && imem_wr_ready_in) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected act=%h_%h exp=none", imem_wr_addr_out, imem_wr_data_out);
                end else begin
                    logic [41:0] e;
                    e = sb.pop_front();
                    if ({imem_wr_addr_out, imem_wr_data_out} !== e) begin
                        bad++;
                        $display("FAIL wr_word act=%h_%h exp=%h_%h", imem_wr_addr_out,
                                 imem_wr_data_out, e[41:32], e[31:0]);
                    end
                end
            end
            if (done_out) n_done++;
            if (err_illegal_out) n_err++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] base);
        base_addr_in = base;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] pco, input logic nop, input logic last,
                        input bit exp_wr, input logic [9:0] ea, input logic [31:0] ed);
        int n;
        opcode_in = op; rs1_in = s1; rs2_in = s2; rd_in = d; inst_function_in = fn;
        immediate_in = imm; pc_offset_in = pco; nop_in = nop; last_in = last;
        enc_valid_in = 1'b1;
        n = 0;
        while (!enc_ready_out && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!enc_ready_out) chk("send_timeout", 64'(enc_ready_out), 64'd1);
        if (exp_wr) sb.push_back({ea, ed});
        @(posedge clk); #1;
        enc_valid_in = 1'b0; last_in = 1'b0; nop_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 64'(done_out), 64'd1);
        @(posedge clk); #1;
        chk({name, "_busy"}, 64'(busy_out), 64'd0);
        chk({name, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int done_snap;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", 64'(imem_wr_en_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_outs", {imem_wr_addr_out, imem_wr_data_out, err_count_out, done_out,
                         err_illegal_out, enc_ready_out}, 64'd0);

        // R-type, single-cycle latency to the write port
        do_start(10'h010);
        send(OP_R_TYPE, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0, 1'b1, 1'b1, 10'h010, 32'h00221820);
        chk("rtype_lat_en", 64'(imem_wr_en_out), 64'd1);
        chk("rtype_lat_addr", 64'(imem_wr_addr_out), 64'h010);
        wait_done("rtype");

        // LW / SW / JPC across the address wrap
        do_start(10'h3FE);
        send(OP_LW, 5'd4, 5'd0, 5'd5, 6'h0, 16'hFFFC, 26'h0, 1'b0, 1'b0, 1'b1, 10'h3FE, 32'h8C85FFFC);
        send(OP_SW, 5'd4, 5'd5, 5'd0, 6'h0, 16'h0008, 26'h0, 1'b0, 1'b0, 1'b1, 10'h3FF, 32'hAC850008);
        send(OP_JPC, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h3FFFFFF, 1'b0, 1'b1, 1'b1, 10'h000, 32'h0BFFFFFF);
        wait_done("stream");

        // Backpressure: two accepted, third blocked, head held stable
        imem_wr_ready_in = 1'b0;
        do_start(10'h100);
        send(OP_ORI, 5'd7, 5'd0, 5'd8, 6'h0, 16'h1234, 26'h0, 1'b0, 1'b0, 1'b1, 10'h100, 32'h34E81234);
        send(OP_BEQZ, 5'd9, 5'd0, 5'd0, 6'h0, 16'hFFF0, 26'h0, 1'b0, 1'b0, 1'b1, 10'h101, 32'h1120FFF0);
        opcode_in = OP_JR; rs1_in = 5'd31; last_in = 1'b1; enc_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", 64'(enc_ready_out), 64'd0);
            chk("bp_hold", {imem_wr_en_out, imem_wr_addr_out, imem_wr_data_out}, {1'b1, 10'h100, 32'h34E81234});
            @(posedge clk); #1;
        end
        imem_wr_ready_in = 1'b1;
        send(OP_JR, 5'd31, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0, 1'b1, 1'b1, 10'h102, 32'h4BE00000);
        wait_done("bp");

        // Illegal opcode between two ADDIs
        do_start(10'h020);
        send(OP_ADDI, 5'd1, 5'd0, 5'd2, 6'h0, 16'h0005, 26'h0, 1'b0, 1'b0, 1'b1, 10'h020, 32'h20220005);
        send(6'h3F, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1111, 26'h1, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("ill_pulse", 64'(err_illegal_out), 64'd1);
        send(OP_ADDI, 5'd2, 5'd0, 5'd3, 6'h0, 16'h0010, 26'h0, 1'b0, 1'b1, 1'b1, 10'h021, 32'h20430010);
        chk("ill_pulse_gone", 64'(err_illegal_out), 64'd0);
        wait_done("ill");
        chk("ill_count", 64'(err_count_out), 64'd1);
        chk("ill_pulses", 64'(n_err), 64'd1);

        // NOP priority; start while ACTIVE ignored; start clears err_count
        do_start(10'h040);
        chk("start_clr_err", 64'(err_count_out), 64'd0);
        send(OP_ADDI, 5'd7, 5'd7, 5'd7, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b1, 1'b0, 1'b1, 10'h040, 32'h00000000);
        do_start(10'h200);
        send(OP_ADDI, 5'd1, 5'd0, 5'd2, 6'h0, 16'h0005, 26'h0, 1'b0, 1'b1, 1'b1, 10'h041, 32'h20220005);
        wait_done("nop");

        // Async reset with two entries buffered
        imem_wr_ready_in = 1'b0;
        do_start(10'h080);
        send(OP_ADDI, 5'd1, 5'd0, 5'd2, 6'h0, 16'h0001, 26'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd2, 6'h0, 16'h0002, 26'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("rstmid_full", {imem_wr_en_out, enc_ready_out}, 2'b10);
        done_snap = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_async", {imem_wr_en_out, busy_out, done_out}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        imem_wr_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rstmid_nodone", 64'(n_done), 64'(done_snap));
        do_start(10'h0F0);
        send(OP_JR, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0, 1'b1, 1'b1, 10'h0F0, 32'h48600000);
        wait_done("rstmid");

        chk("done_total", 64'(n_done), 64'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
